pc_unit: RTL and testbench

// Parametrised program-counter unit for the MIPS fetch stage, successor to the plain PC register.

---
 rtl/pc_unit.sv | 63 ++++++
 tb/tb_pc_unit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// pc_unit: MIPS fetch-stage PC with prioritised redirects, stall hold and a buffered redirect
module pc_unit #(
  parameter int WIDTH = 32,
  parameter int INC = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC = WIDTH'(32'h180)
)(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_br_take,
  input  logic [WIDTH-1:0] i_br_tgt,
  input  logic             i_jmp,
  input  logic [WIDTH-1:0] i_jmp_tgt,
  input  logic             i_jr,
  input  logic [WIDTH-1:0] i_jr_tgt,
  input  logic             i_exc,
  input  logic             i_eret,
  input  logic [WIDTH-1:0] i_epc,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_pc_inc,
  output logic             o_valid,
  output logic             o_misalign
);
  typedef enum logic [1:0] {BOOT, RUN, HOLD} state_t;
  state_t state;
  logic [2:0] new_pri, pend_pri;
  logic [WIDTH-1:0] new_tgt, pend_addr;
  // priority 0 means "no redirect" and doubles as the empty marker for the pending buffer
  always_comb begin
    new_pri = i_exc ? 3'd5 : i_eret ? 3'd4 : i_jr ? 3'd3 : i_jmp ? 3'd2 : i_br_take ? 3'd1 : 3'd0;
    new_tgt = i_exc ? EXC_VEC : i_eret ? i_epc : i_jr ? i_jr_tgt : i_jmp ? i_jmp_tgt :
              i_br_take ? i_br_tgt : o_pc_inc;
  end
  assign o_pc_inc = o_pc + WIDTH'(INC);
  assign o_misalign = |(o_pc & WIDTH'(INC - 1));
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= BOOT;
      o_pc <= RESET_VEC;
      o_valid <= 1'b0;
      pend_pri <= 3'd0;
      pend_addr <= '0;
    end else if (state == BOOT) begin
      state <= RUN;
      o_valid <= 1'b1;
      if (i_exc) o_pc <= EXC_VEC;
    end else if (i_exc) begin
      state <= RUN;
      o_pc <= EXC_VEC;
      pend_pri <= 3'd0;
    end else if (i_stall) begin
      state <= HOLD;
      if (new_pri >= pend_pri) begin
        pend_pri <= new_pri;
        pend_addr <= new_tgt;
      end
    end else begin
      state <= RUN;
      pend_pri <= 3'd0;
      o_pc <= pend_pri > new_pri ? pend_addr : new_tgt;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench for pc_unit, directed scenarios then randomized traffic
module tb_pc_unit;
  logic clk = 0, rst_n = 0;
  logic stall = 0, br = 0, jmp = 0, jr = 0, exc = 0, eret = 0;
  logic [31:0] br_tgt = 0, jmp_tgt = 0, jr_tgt = 0, epc = 0;
  logic [31:0] pc, pc_inc;
  logic valid, misalign;
  int checks = 0, errors = 0;

  typedef struct {logic [31:0] pc; logic [31:0] inc; logic valid; logic mis;} exp_t;
  exp_t q[$];

  logic [31:0] m_pc, m_pa;
  logic m_valid, m_boot;
  int m_pp;

  pc_unit dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_br_take(br), .i_br_tgt(br_tgt),
    .i_jmp(jmp), .i_jmp_tgt(jmp_tgt), .i_jr(jr), .i_jr_tgt(jr_tgt), .i_exc(exc),
    .i_eret(eret), .i_epc(epc), .o_pc(pc), .o_pc_inc(pc_inc), .o_valid(valid),
    .o_misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_valid = 0; m_boot = 1; m_pp = 0; m_pa = 0;
    q.delete();
  endtask

  // Reference: pick the highest-ranked active request, then apply boot/exception/stall rules
  task automatic model_step();
    logic [31:0] tg[6];
    bit rq[6];
    int np;
    logic [31:0] nt;
    rq = '{0, br, jmp, jr, eret, exc};
    tg = '{0, br_tgt, jmp_tgt, jr_tgt, epc, 32'h180};
    np = 0; nt = 0;
    for (int k = 1; k < 6; k++) if (rq[k]) begin np = k; nt = tg[k]; end
    if (m_boot) begin
      m_boot = 0; m_valid = 1;
      if (exc) m_pc = 32'h180;
    end else if (exc) begin
      m_pc = 32'h180; m_pp = 0;
    end else if (stall) begin
      if (np != 0 && np >= m_pp) begin m_pp = np; m_pa = nt; end
    end else begin
      if (m_pp > np) m_pc = m_pa;
      else if (np != 0) m_pc = nt;
      else m_pc = m_pc + 32'd4;
      m_pp = 0;
    end
    q.push_back('{m_pc, m_pc + 32'd4, m_valid, m_pc[1:0] != 2'b00});
  endtask

  task automatic tick(input bit s = 0, x = 0, e = 0, r = 0, j = 0, b = 0,
                      input logic [31:0] bt = 0, jt = 0, rt = 0, et = 0);
    stall = s; exc = x; eret = e; jr = r; jmp = j; br = b;
    br_tgt = bt; jmp_tgt = jt; jr_tgt = rt; epc = et;
    model_step();
    @(negedge clk);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_inc", pc_inc, e.inc);
      chk("valid", {31'b0, valid}, {31'b0, e.valid});
      chk("misalign", {31'b0, misalign}, {31'b0, e.mis});
    end
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'b0, valid}, 32'h0);
    rst_n = 1;
    repeat (4) tick();
    tick();
    tick(.b(1), .bt(32'h40));
    tick(.j(1), .b(1), .bt(32'h40), .jt(32'h80));
    tick(.j(1), .jt(32'h20));
    tick(.s(1)); tick(.s(1), .b(1), .bt(32'h100)); tick(.s(1));
    tick(); tick();
    tick(.s(1), .j(1), .jt(32'h200)); tick(.s(1), .x(1)); tick();
    tick(.r(1), .rt(32'hFFFF_FFFC)); tick();
    tick(.r(1), .rt(32'h42)); tick();
    tick(.s(1), .b(1), .bt(32'h300));
    stall = 1;
    rst_n = 0;
    #1;
    chk("async_reset_pc", pc, 32'h0);
    chk("async_reset_valid", {31'b0, valid}, 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (3) tick();
    rst_n = 0;
    @(negedge clk);
    model_reset();
    rst_n = 1;
    tick(.x(1)); tick();
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t[4];
      for (int k = 0; k < 4; k++) begin
        t[k] = $urandom & ~32'h3;
        if ($urandom_range(0, 7) == 0) t[k] = t[k] | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) t[k] = 32'hFFFF_FFF0 | (t[k] & 32'hF);
      end
      tick($urandom_range(0, 9) < 4, $urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 8) == 0, $urandom_range(0, 6) == 0,
           t[0], t[1], t[2], t[3]);
    end
    stall = 0; exc = 0; eret = 0; jr = 0; jmp = 0; br = 0;
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
